// File: rtl/rob.sv
// 16-entry reorder buffer: in-order commit, CDB writeback, and a one-cycle FLUSH
// on a mispredicted commit. Optional operand forwarding is enabled by macro ROB_FORWARD_EN.
module rob (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        issue_sgn,
  input  logic [5:0]  issue_rd,
  input  logic [31:0] issue_pc,
  output logic [4:0]  rob_new_entry,
  output logic        rob_full,
  input  logic        cdb_valid,
  input  logic [4:0]  cdb_entry,
  input  logic [31:0] cdb_result,
  input  logic        cdb_mispredict,
  input  logic [31:0] cdb_target,
  output logic        commit_sgn,
  output logic [4:0]  rob_entry,
  output logic [5:0]  rob_des,
  output logic [31:0] rob_result,
  output logic        rollback,
  output logic [31:0] rollback_pc,
  input  logic [4:0]  qry1_entry,
  input  logic [4:0]  qry2_entry,
  output logic        qry1_ready,
  output logic        qry2_ready,
  output logic [31:0] qry1_value,
  output logic [31:0] qry2_value
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t      r_state;
  logic [15:0] r_busy;
  logic [15:0] r_ready;
  logic [15:0] r_mispred;
  logic [5:0]  r_rd     [16];
  logic [31:0] r_result [16];
  logic [31:0] r_target [16];
  logic [3:0]  r_head;
  logic [3:0]  r_tail;
  logic [4:0]  r_count;
  logic        r_commit_sgn;
  logic [4:0]  r_rob_entry;
  logic [5:0]  r_rob_des;
  logic [31:0] r_rob_result;
  logic        r_rollback;
  logic [31:0] r_rollback_pc;

  logic w_do_issue;
  logic w_do_cdb;
  logic w_do_commit;

  assign rob_new_entry = {1'b0, r_tail};
  assign rob_full      = (r_count == 5'd16) || (r_state == S_FLUSH);
  assign w_do_issue    = issue_sgn && !rob_full;
  assign w_do_cdb      = cdb_valid && !cdb_entry[4] && r_busy[cdb_entry[3:0]];
  // ready is the registered flag, so a CDB write to head commits one cycle later
  assign w_do_commit   = (r_state == S_RUN) && (r_count != 5'd0) && r_ready[r_head];

  assign commit_sgn  = r_commit_sgn;
  assign rob_entry   = r_rob_entry;
  assign rob_des     = r_rob_des;
  assign rob_result  = r_rob_result;
  assign rollback    = r_rollback;
  assign rollback_pc = r_rollback_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_RUN;
      r_busy        <= '0;
      r_ready       <= '0;
      r_mispred     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_commit_sgn  <= 1'b0;
      r_rob_entry   <= 5'd16;
      r_rob_des     <= 6'b100000;
      r_rob_result  <= '0;
      r_rollback    <= 1'b0;
      r_rollback_pc <= '0;
      for (int i = 0; i < 16; i++) begin
        r_rd[i]     <= 6'b100000;
        r_result[i] <= '0;
        r_target[i] <= '0;
      end
    end else if (!rdy) begin
      r_commit_sgn <= 1'b0;
      r_rollback   <= 1'b0;
    end else begin
      r_commit_sgn <= 1'b0;
      r_rollback   <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_do_cdb) begin
            r_ready[cdb_entry[3:0]]   <= 1'b1;
            r_result[cdb_entry[3:0]]  <= cdb_result;
            r_mispred[cdb_entry[3:0]] <= cdb_mispredict;
            r_target[cdb_entry[3:0]]  <= cdb_target;
          end
          if (w_do_issue) begin
            r_busy[r_tail]    <= 1'b1;
            r_ready[r_tail]   <= 1'b0;
            r_mispred[r_tail] <= 1'b0;
            r_rd[r_tail]      <= issue_rd;
            r_tail            <= r_tail + 4'd1;
          end
          if (w_do_commit) begin
            r_commit_sgn    <= 1'b1;
            r_rob_entry     <= {1'b0, r_head};
            r_rob_des       <= r_rd[r_head];
            r_rob_result    <= r_result[r_head];
            r_busy[r_head]  <= 1'b0;
            r_ready[r_head] <= 1'b0;
            r_head          <= r_head + 4'd1;
            if (r_mispred[r_head]) begin
              r_state       <= S_FLUSH;
              r_rollback_pc <= r_target[r_head];
            end
          end
          r_count <= r_count + {4'd0, w_do_issue} - {4'd0, w_do_commit};
        end
        S_FLUSH: begin
          r_rollback <= 1'b1;
          r_busy     <= '0;
          r_ready    <= '0;
          r_mispred  <= '0;
          r_head     <= '0;
          r_tail     <= '0;
          r_count    <= '0;
          r_state    <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef ROB_FORWARD_EN
  logic w_unused_pc;
  assign w_unused_pc = ^issue_pc;

  // CDB bypass wins so a consumer sees a result in the cycle it is broadcast
  always_comb begin
    qry1_ready = 1'b0;
    qry1_value = '0;
    if (!qry1_entry[4]) begin
      if (cdb_valid && cdb_entry == qry1_entry) begin
        qry1_ready = 1'b1;
        qry1_value = cdb_result;
      end else if (r_busy[qry1_entry[3:0]] && r_ready[qry1_entry[3:0]]) begin
        qry1_ready = 1'b1;
        qry1_value = r_result[qry1_entry[3:0]];
      end
    end
  end

  always_comb begin
    qry2_ready = 1'b0;
    qry2_value = '0;
    if (!qry2_entry[4]) begin
      if (cdb_valid && cdb_entry == qry2_entry) begin
        qry2_ready = 1'b1;
        qry2_value = cdb_result;
      end else if (r_busy[qry2_entry[3:0]] && r_ready[qry2_entry[3:0]]) begin
        qry2_ready = 1'b1;
        qry2_value = r_result[qry2_entry[3:0]];
      end
    end
  end
`else
  logic w_unused_in;
  assign w_unused_in = ^{issue_pc, qry1_entry, qry2_entry};

  assign qry1_ready = 1'b0;
  assign qry2_ready = 1'b0;
  assign qry1_value = '0;
  assign qry2_value = '0;
`endif

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a queue of issued tags plus a result table form the
// commit scoreboard; every commit pulse is checked against the queue head.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        issue_sgn = 1'b0;
  logic [5:0]  issue_rd = '0;
  logic [31:0] issue_pc = '0;
  logic [4:0]  rob_new_entry;
  logic        rob_full;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_entry = '0;
  logic [31:0] cdb_result = '0;
  logic        cdb_mispredict = 1'b0;
  logic [31:0] cdb_target = '0;
  logic        commit_sgn;
  logic [4:0]  rob_entry;
  logic [5:0]  rob_des;
  logic [31:0] rob_result;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic [4:0]  qry1_entry = 5'd16;
  logic [4:0]  qry2_entry = 5'd16;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_value, qry2_value;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_sgn(issue_sgn), .issue_rd(issue_rd), .issue_pc(issue_pc),
    .rob_new_entry(rob_new_entry), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_result(cdb_result),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .commit_sgn(commit_sgn), .rob_entry(rob_entry), .rob_des(rob_des),
    .rob_result(rob_result), .rollback(rollback), .rollback_pc(rollback_pc),
    .qry1_entry(qry1_entry), .qry2_entry(qry2_entry),
    .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_value(qry1_value), .qry2_value(qry2_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] tag;
    logic [5:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] res_m[16];
  int          errors = 0;
  int          checks = 0;
  int          n_commits = 0;

`ifdef ROB_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1ns later, and score any commit pulse
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (commit_sgn === 1'b1) begin
      n_commits++;
      chk("sb_expected_commit", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_rob_entry", {27'd0, rob_entry}, {27'd0, e.tag});
        chk("sb_rob_des", {26'd0, rob_des}, {26'd0, e.rd});
        chk("sb_rob_result", rob_result, res_m[e.tag[3:0]]);
      end
    end
  endtask

  task automatic issue(input logic [5:0] rd);
    exp_q.push_back('{tag: rob_new_entry, rd: rd});
    issue_sgn = 1'b1;
    issue_rd  = rd;
    cyc();
    issue_sgn = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] res,
                     input logic mp, input logic [31:0] tgt);
    res_m[tag[3:0]] = res;
    cdb_valid      = 1'b1;
    cdb_entry      = tag;
    cdb_result     = res;
    cdb_mispredict = mp;
    cdb_target     = tgt;
    cyc();
    cdb_valid      = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) res_m[i] = '0;

    // reset state
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_commit_sgn", {31'd0, commit_sgn}, 32'd0);
    chk("rst_rollback", {31'd0, rollback}, 32'd0);
    chk("rst_rob_entry", {27'd0, rob_entry}, 32'd16);
    chk("rst_rob_des", {26'd0, rob_des}, 32'h20);
    chk("rst_rob_result", rob_result, 32'd0);
    chk("rst_rollback_pc", rollback_pc, 32'd0);
    chk("rst_new_entry", {27'd0, rob_new_entry}, 32'd0);
    chk("rst_full", {31'd0, rob_full}, 32'd0);
    rst = 1'b1;

    // basic issue / writeback / commit latency
    issue(6'd5);
    cdb(5'd0, 32'h1234, 1'b0, 32'd0);
    chk("basic_no_early_commit", {31'd0, commit_sgn}, 32'd0);
    cyc();
    chk("basic_commit_pulse", {31'd0, commit_sgn}, 32'd1);
    cyc();
    chk("basic_pulse_one_cycle", {31'd0, commit_sgn}, 32'd0);
    chk("basic_new_entry", {27'd0, rob_new_entry}, 32'd1);

    // fill all 16 entries, 17th issue ignored, commit grants no same-cycle credit
    do_reset();
    for (int i = 0; i < 16; i++) issue(6'(i));
    chk("full_after_16", {31'd0, rob_full}, 32'd1);
    chk("full_new_entry_wrap", {27'd0, rob_new_entry}, 32'd0);
    issue_sgn = 1'b1; issue_rd = 6'd63;
    cyc();
    issue_sgn = 1'b0;
    chk("full_17th_ignored", {27'd0, rob_new_entry}, 32'd0);
    chk("full_still", {31'd0, rob_full}, 32'd1);
    cdb(5'd0, 32'h100, 1'b0, 32'd0);
    chk("full_before_commit", {31'd0, rob_full}, 32'd1);
    issue_sgn = 1'b1; issue_rd = 6'd50;
    cyc();
    issue_sgn = 1'b0;
    chk("full_commit_seen", {31'd0, commit_sgn}, 32'd1);
    chk("full_no_same_cycle_credit", {27'd0, rob_new_entry}, 32'd0);
    chk("full_released", {31'd0, rob_full}, 32'd0);
    base = n_commits;
    for (int i = 1; i < 16; i++) cdb(5'(i), 32'h100 + i, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("drain_commit_count", n_commits - base, 32'd15);
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    // out-of-order writeback commits in order on consecutive cycles
    do_reset();
    issue(6'd7);
    issue(6'd8);
    cdb(5'd1, 32'hB, 1'b0, 32'd0);
    chk("ooo_no_commit_tag1", {31'd0, commit_sgn}, 32'd0);
    cdb(5'd0, 32'hA, 1'b0, 32'd0);
    cyc();
    chk("ooo_commit_first", {31'd0, commit_sgn}, 32'd1);
    chk("ooo_tag_first", {27'd0, rob_entry}, 32'd0);
    cyc();
    chk("ooo_commit_second", {31'd0, commit_sgn}, 32'd1);
    chk("ooo_tag_second", {27'd0, rob_entry}, 32'd1);

    // mispredicted commit then one-cycle flush
    issue(6'd9);
    issue(6'd10);
    cdb(5'd2, 32'h77, 1'b1, 32'h80);
    cdb(5'd3, 32'h33, 1'b0, 32'd0);
    chk("mp_commit_pulse", {31'd0, commit_sgn}, 32'd1);
    chk("mp_commit_tag", {27'd0, rob_entry}, 32'd2);
    chk("mp_no_rollback_yet", {31'd0, rollback}, 32'd0);
    chk("mp_full_in_flush", {31'd0, rob_full}, 32'd1);
    cyc();
    chk("mp_rollback", {31'd0, rollback}, 32'd1);
    chk("mp_rollback_pc", rollback_pc, 32'h80);
    chk("mp_no_commit_in_flush", {31'd0, commit_sgn}, 32'd0);
    chk("mp_new_entry_zero", {27'd0, rob_new_entry}, 32'd0);
    chk("mp_not_full", {31'd0, rob_full}, 32'd0);
    exp_q.delete();
    base = n_commits;
    cyc();
    chk("mp_rollback_pulse", {31'd0, rollback}, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    chk("mp_flushed_no_commit", n_commits - base, 32'd0);

    // rdy freeze holds a ready head
    issue(6'd1);
    cdb(5'd0, 32'h42, 1'b0, 32'd0);
    rdy = 1'b0;
    issue_sgn = 1'b1; issue_rd = 6'd2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_no_commit", {31'd0, commit_sgn}, 32'd0);
    end
    chk("frz_no_issue", {27'd0, rob_new_entry}, 32'd1);
    issue_sgn = 1'b0;
    rdy = 1'b1;
    cyc();
    chk("frz_commit_after", {31'd0, commit_sgn}, 32'd1);
    chk("frz_commit_tag", {27'd0, rob_entry}, 32'd0);

    // asynchronous reset mid-cycle
    #2 rst = 1'b0;
    #1;
    chk("arst_commit_sgn", {31'd0, commit_sgn}, 32'd0);
    chk("arst_rob_entry", {27'd0, rob_entry}, 32'd16);
    chk("arst_rob_des", {26'd0, rob_des}, 32'h20);
    chk("arst_rob_result", rob_result, 32'd0);
    chk("arst_rollback_pc", rollback_pc, 32'd0);
    chk("arst_new_entry", {27'd0, rob_new_entry}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;

    // operand lookup
    for (int i = 0; i < 4; i++) issue(6'(20 + i));
    cdb(5'd3, 32'h55, 1'b0, 32'd0);
    qry1_entry = 5'd3;
    qry2_entry = 5'd2;
    #1;
    chk("qry1_ready", {31'd0, qry1_ready}, {31'd0, FWD});
    chk("qry1_value", qry1_value, FWD ? 32'h55 : 32'd0);
    chk("qry2_not_ready", {31'd0, qry2_ready}, 32'd0);
    cdb_valid = 1'b1; cdb_entry = 5'd2; cdb_result = 32'h66;
    #1;
    chk("qry2_bypass_ready", {31'd0, qry2_ready}, {31'd0, FWD});
    chk("qry2_bypass_value", qry2_value, FWD ? 32'h66 : 32'd0);
    cdb_valid = 1'b0;
    qry1_entry = 5'd16;
    #1;
    chk("qry1_null_tag", {31'd0, qry1_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
